ma_threshold_detector: RTL and testbench
========================================

// Module: ma_threshold_detector
// PURPOSE
//  Downstream of the moving-average stage: consumes smoothed signed fixed-point samples and detects
//  threshold crossings with hysteresis and debounce (HOLD_N consecutive qualifying samples).
//  Emits a one-cycle event (direction + sample-index timestamp) and a steady level flag
//  for the control/logging logic that follows.
// PARAMETERS
//  DATA_W  16  width of signed two's-complement sample and threshold words
//  HOLD_N  4   consecutive qualifying samples required to change level; legal range >= 1
//  CNT_W   32  width of sample-index counter and event timestamp
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-high
//  en         in   1       global enable; low freezes all state
//  in_valid   in   1       in_data valid this cycle
//  in_data    in   DATA_W  signed smoothed sample from the moving-average stage
//  thr_hi     in   DATA_W  signed rise threshold, quasi-static
//  thr_lo     in   DATA_W  signed fall threshold, quasi-static
//  evt_valid  out  1       one-cycle event pulse
//  evt_rise   out  1       event direction: 1 = rising (to HIGH), 0 = falling (to LOW)
//  evt_stamp  out  CNT_W   index of the sample that completed the debounce
//  level      out  1       debounced level; 1 in HIGH and FALL_PEND states
//  sample_cnt out  CNT_W   count of accepted samples, mod 2^CNT_W
//  cfg_err    out  1       registered (thr_lo > thr_hi), signed compare
// BEHAVIOUR
//  - Accept: a sample is accepted on a rising clk edge with en && in_valid; no other edge changes
//    state, run, or sample_cnt.
//  - Reset (async, any time, including mid-pending): state=LOW, run=0, sample_cnt=0,
//    evt_valid=0, evt_rise=0, evt_stamp=0, level=0, cfg_err=0. A pending debounce is discarded.
//  - Compares: all signed. Rise qualifies on in_data > thr_hi (strict);
//    fall qualifies on in_data < thr_lo (strict).
//  - run counter: width $clog2(HOLD_N+1).
//  - sample_cnt: increments by 1 per accepted sample, wraps 2^CNT_W-1 -> 0.
//    Stamp = sample_cnt value before the increment, so the first accepted sample is index 0.
//  - FSM (per accepted sample):
//    LOW:       rise-qualifying -> if HOLD_N==1, go HIGH + event; else go RISE_PEND, run=1.
//               Otherwise stay LOW.
//    RISE_PEND: rise-qualifying -> run+1; when run+1==HOLD_N, go HIGH + rise event, run=0.
//               Non-qualifying -> go LOW, run=0.
//    HIGH:      fall-qualifying -> if HOLD_N==1, go LOW + event; else go FALL_PEND, run=1.
//               Otherwise stay HIGH.
//    FALL_PEND: fall-qualifying -> run+1; when run+1==HOLD_N, go LOW + fall event, run=0.
//               Non-qualifying -> go HIGH, run=0.
//  - Event timing: evt_valid, evt_rise, evt_stamp are registered.
//    evt_valid is high for exactly the one cycle after the completing accept edge
//    (latency 1 clk), then returns low even if en drops.
//    evt_rise and evt_stamp hold their last value until the next event.
//  - level is registered and updates on the same edge as evt_valid.
//  - en low: FSM, run, and sample_cnt are frozen; in_valid is ignored; cfg_err keeps updating.
//  - Back-to-back events: with HOLD_N==1, consecutive accepted samples can produce events
//    in consecutive cycles; each event gets its own pulse.
//  - Misconfiguration (thr_lo > thr_hi): FSM rules are still applied verbatim;
//    cfg_err=1 flags the condition. No clamping.
//  - Mid-operation threshold change: takes effect at the next accept; run is not cleared.
// TESTING
//  1. Reset: assert rst mid-stream -> all outputs 0 asynchronously;
//     first post-reset accepted sample gets stamp 0.
//  2. HOLD_N=4, thr_hi=100, thr_lo=50; samples 0,120,130,140,150 -> one evt_valid pulse
//     1 clk after the 5th accept, evt_rise=1, evt_stamp=4, level=1.
//  3. Glitch: LOW, samples 120,130,90,120,0 -> no event, level stays 0;
//     FSM back to LOW after 90; 100 (equal to thr_hi) never qualifies.
//  4. Hysteresis: from HIGH, ten samples of 80 -> no event;
//     then 40,40,40,40 -> fall event, evt_rise=0, level=0.
//  5. Gaps: repeat test 2 with in_valid idle cycles and en low between samples
//     -> identical event and stamp; sample_cnt counts accepts only; evt pulse stays 1 cycle.
//  6. Wrap/abort: CNT_W=4, 20 accepted samples -> sample_cnt wraps 15->0 and stamps follow;
//     rst during RISE_PEND at run=3 -> no event afterwards.

Source files
------------

// File: rtl/ma_threshold_detector.sv
// Threshold crossing detector with hysteresis and debounce.
// Consumes smoothed signed samples, tracks a debounced HIGH/LOW level and
// emits a one-cycle event carrying direction and the index of the sample
// that completed the debounce.
module ma_threshold_detector #(
    parameter int DATA_W = 16,
    parameter int HOLD_N = 4,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [DATA_W-1:0] thr_hi,
    input  logic signed [DATA_W-1:0] thr_lo,
    output logic                     evt_valid,
    output logic                     evt_rise,
    output logic        [CNT_W-1:0]  evt_stamp,
    output logic                     level,
    output logic        [CNT_W-1:0]  sample_cnt,
    output logic                     cfg_err
);

    localparam int RUN_W = $clog2(HOLD_N + 1);
    localparam logic [RUN_W-1:0] HOLD_R  = RUN_W'(HOLD_N);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    localparam logic [1:0] ST_LOW       = 2'd0;
    localparam logic [1:0] ST_RISE_PEND = 2'd1;
    localparam logic [1:0] ST_HIGH      = 2'd2;
    localparam logic [1:0] ST_FALL_PEND = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             evt_valid_q, evt_valid_d;
    logic             evt_rise_q, evt_rise_d;
    logic [CNT_W-1:0] evt_stamp_q, evt_stamp_d;
    logic             level_q, level_d;
    logic             cfg_err_q, cfg_err_d;

    logic             accept;
    logic             rise_ok;
    logic             fall_ok;
    logic             fire;
    logic [RUN_W-1:0] run_inc;

    // Next-state logic: debounce FSM advances only on accepted samples.
    always_comb begin
        accept      = en && in_valid;
        rise_ok     = in_data > thr_hi;
        fall_ok     = in_data < thr_lo;
        run_inc     = run_q + RUN_ONE;
        fire        = 1'b0;
        state_d     = state_q;
        run_d       = run_q;
        cnt_d       = cnt_q;
        evt_valid_d = 1'b0;
        evt_rise_d  = evt_rise_q;
        evt_stamp_d = evt_stamp_q;
        cfg_err_d   = thr_lo > thr_hi;

        if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
            case (state_q)
                ST_LOW: begin
                    if (rise_ok) begin
                        if (HOLD_N == 1) begin
                            state_d = ST_HIGH;
                            fire    = 1'b1;
                        end else begin
                            state_d = ST_RISE_PEND;
                            run_d   = RUN_ONE;
                        end
                    end
                end
                ST_RISE_PEND: begin
                    if (rise_ok) begin
                        if (run_inc == HOLD_R) begin
                            state_d = ST_HIGH;
                            run_d   = '0;
                            fire    = 1'b1;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        state_d = ST_LOW;
                        run_d   = '0;
                    end
                end
                ST_HIGH: begin
                    if (fall_ok) begin
                        if (HOLD_N == 1) begin
                            state_d = ST_LOW;
                            fire    = 1'b1;
                        end else begin
                            state_d = ST_FALL_PEND;
                            run_d   = RUN_ONE;
                        end
                    end
                end
                ST_FALL_PEND: begin
                    if (fall_ok) begin
                        if (run_inc == HOLD_R) begin
                            state_d = ST_LOW;
                            run_d   = '0;
                            fire    = 1'b1;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        state_d = ST_HIGH;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_LOW;
                    run_d   = '0;
                end
            endcase
        end

        if (fire) begin
            evt_valid_d = 1'b1;
            evt_rise_d  = (state_d == ST_HIGH);
            evt_stamp_d = cnt_q;
        end

        // Level tracks the debounced side, pending states keep the old side.
        level_d = (state_d == ST_HIGH) || (state_d == ST_FALL_PEND);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOW;
            run_q       <= '0;
            cnt_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_rise_q  <= 1'b0;
            evt_stamp_q <= '0;
            level_q     <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            cnt_q       <= cnt_d;
            evt_valid_q <= evt_valid_d;
            evt_rise_q  <= evt_rise_d;
            evt_stamp_q <= evt_stamp_d;
            level_q     <= level_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign evt_valid  = evt_valid_q;
    assign evt_rise   = evt_rise_q;
    assign evt_stamp  = evt_stamp_q;
    assign level      = level_q;
    assign sample_cnt = cnt_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_ma_threshold_detector.sv
// Bench for ma_threshold_detector: two instances (HOLD_N=4/CNT_W=32 and
// HOLD_N=1/CNT_W=4) share stimulus and are compared every cycle against a
// streak-count reference model.
module tb_ma_threshold_detector;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_data = '0;
    logic signed [15:0] thr_hi = 16'sd100;
    logic signed [15:0] thr_lo = 16'sd50;

    logic        evt_valid_a, evt_rise_a, level_a, cfg_err_a;
    logic [31:0] evt_stamp_a, sample_cnt_a;
    logic        evt_valid_b, evt_rise_b, level_b, cfg_err_b;
    logic [3:0]  evt_stamp_b, sample_cnt_b;

    ma_threshold_detector #(.DATA_W(16), .HOLD_N(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .evt_valid(evt_valid_a),
        .evt_rise(evt_rise_a), .evt_stamp(evt_stamp_a), .level(level_a),
        .sample_cnt(sample_cnt_a), .cfg_err(cfg_err_a)
    );

    ma_threshold_detector #(.DATA_W(16), .HOLD_N(1), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .evt_valid(evt_valid_b),
        .evt_rise(evt_rise_b), .evt_stamp(evt_stamp_b), .level(level_b),
        .sample_cnt(sample_cnt_b), .cfg_err(cfg_err_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // reference model state, index 0 = dut, 1 = dut_w
    int              hn[2] = '{4, 1};
    longint unsigned msk[2] = '{64'hFFFF_FFFF, 64'hF};
    int              m_streak[2];
    bit              m_level[2];
    longint unsigned m_cnt[2];
    bit              m_ev[2];
    bit              m_er[2];
    longint unsigned m_st[2];
    bit              m_cfg;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_streak[i] = 0; m_level[i] = 0; m_cnt[i] = 0;
            m_ev[i] = 0; m_er[i] = 0; m_st[i] = 0;
        end
        m_cfg = 0;
    endtask

    // One accepted-or-not clock edge: a level flips after hn consecutive
    // samples qualifying towards the opposite side.
    task automatic model_edge();
        bit q;
        m_cfg = (thr_lo > thr_hi);
        for (int i = 0; i < 2; i++) begin
            m_ev[i] = 0;
            if (en && in_valid) begin
                q = m_level[i] ? (in_data < thr_lo) : (in_data > thr_hi);
                m_streak[i] = q ? m_streak[i] + 1 : 0;
                if (m_streak[i] == hn[i]) begin
                    m_level[i]  = !m_level[i];
                    m_ev[i]     = 1;
                    m_er[i]     = m_level[i];
                    m_st[i]     = m_cnt[i];
                    m_streak[i] = 0;
                end
                m_cnt[i] = (m_cnt[i] + 1) & msk[i];
            end
        end
    endtask

    task automatic compare_all();
        check_eq("evt_valid_a",  64'(evt_valid_a),  64'(m_ev[0]));
        check_eq("evt_rise_a",   64'(evt_rise_a),   64'(m_er[0]));
        check_eq("evt_stamp_a",  64'(evt_stamp_a),  m_st[0]);
        check_eq("level_a",      64'(level_a),      64'(m_level[0]));
        check_eq("sample_cnt_a", 64'(sample_cnt_a), m_cnt[0]);
        check_eq("cfg_err_a",    64'(cfg_err_a),    64'(m_cfg));
        check_eq("evt_valid_b",  64'(evt_valid_b),  64'(m_ev[1]));
        check_eq("evt_rise_b",   64'(evt_rise_b),   64'(m_er[1]));
        check_eq("evt_stamp_b",  64'(evt_stamp_b),  m_st[1]);
        check_eq("level_b",      64'(level_b),      64'(m_level[1]));
        check_eq("sample_cnt_b", 64'(sample_cnt_b), m_cnt[1]);
        check_eq("cfg_err_b",    64'(cfg_err_b),    64'(m_cfg));
    endtask

    // Drive one cycle: inputs set 1 time unit after the previous edge.
    task automatic step(input bit e, input bit v, input int d);
        en = e; in_valid = v; in_data = 16'(d);
        @(posedge clk);
        cyc++;
        if (!rst) model_edge();
        #1;
        compare_all();
    endtask

    task automatic sample(input int d);
        step(1, 1, d);
    endtask

    // Asynchronous reset asserted and released between clock edges.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1 model_reset();
        compare_all();
        #1 rst = 1'b0;
    endtask

    int r, any_evt;
    int samp5[5] = '{0, 120, 130, 140, 150};

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 compare_all();
        rst = 1'b0;

        // basic rise after four qualifying samples, stamp 4
        foreach (samp5[i]) sample(samp5[i]);
        check_eq("t2_evt", 64'(evt_valid_a), 64'd1);
        check_eq("t2_stamp", 64'(evt_stamp_a), 64'd4);
        check_eq("t2_rise", 64'(evt_rise_a), 64'd1);
        step(1, 0, 0);
        check_eq("t2_pulse_len", 64'(evt_valid_a), 64'd0);

        // return LOW, then a glitchy rise and samples equal to thr_hi
        repeat (4) sample(0);
        sample(120); sample(130); sample(90); sample(120); sample(0);
        repeat (5) sample(100);
        check_eq("t3_level", 64'(level_a), 64'd0);

        // hysteresis band holds HIGH, then a fall
        repeat (4) sample(120);
        repeat (10) sample(80);
        check_eq("t4_hold_high", 64'(level_a), 64'd1);
        repeat (4) sample(40);
        check_eq("t4_fall_rise", 64'(evt_rise_a), 64'd0);
        check_eq("t4_level", 64'(level_a), 64'd0);

        // gaps: idle and en-low cycles between accepts
        async_reset();
        foreach (samp5[i]) begin
            step(1, 0, 999);
            step(0, 1, 999);
            sample(samp5[i]);
        end
        check_eq("t5_stamp", 64'(evt_stamp_a), 64'd4);
        check_eq("t5_cnt", 64'(sample_cnt_a), 64'd5);
        step(0, 1, 0);
        check_eq("t5_pulse_len", 64'(evt_valid_a), 64'd0);

        // counter wrap on the narrow instance, abort during pending rise
        async_reset();
        repeat (20) sample(0);
        check_eq("t6_wrap", 64'(sample_cnt_b), 64'd4);
        repeat (3) sample(120);
        async_reset();
        check_eq("t6_abort_cnt", 64'(sample_cnt_a), 64'd0);
        any_evt = 0;
        sample(120);
        check_eq("t6_first_stamp_cnt", 64'(sample_cnt_a), 64'd1);
        repeat (4) begin
            sample(0);
            any_evt |= int'(evt_valid_a);
        end
        check_eq("t6_no_evt", 64'(any_evt), 64'd0);

        // misconfigured thresholds are flagged
        thr_lo = 16'sd150;
        step(0, 0, 0);
        check_eq("cfg_err_set", 64'(cfg_err_a), 64'd1);
        thr_lo = 16'sd50;

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(99);
            if (r < 2) begin
                thr_hi = 16'($urandom_range(200));
                thr_lo = 16'(int'($urandom_range(250)) - 100);
            end
            if (r == 99) async_reset();
            step($urandom_range(9) != 0, $urandom_range(9) < 7,
                 int'($urandom_range(500)) - 200);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
